// File: rtl/result_tx_serializer.sv
// Streams an M x P matrix of 32-bit words from a result RAM to a byte-wide
// transmitter, row-major, each word sent MSB byte first.
module result_tx_serializer #(
  parameter int MAX_M  = 4,
  parameter int MAX_P  = 4,
  parameter int DIM_W  = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  m_dim,
  input  logic [DIM_W-1:0]  p_dim,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves when tx_valid & tx_ready are both high on a rising
  // edge; tx_data holds steady while tx_valid is high and tx_ready is low.
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  state_t             state;
  logic [DIM_W-1:0]   m_lat, p_lat, i, j;
  logic [DIM_W-1:0]   m_clamp, p_clamp, next_i, next_j;
  logic [1:0]         bidx;
  logic [31:0]        word;
  logic               last_col, last_row;
  logic [ADDR_W-1:0]  next_addr;

  assign state_dbg = state;

  always_comb begin
    m_clamp   = (m_dim > DIM_W'(MAX_M)) ? DIM_W'(MAX_M) : m_dim;
    p_clamp   = (p_dim > DIM_W'(MAX_P)) ? DIM_W'(MAX_P) : p_dim;
    last_col  = (j == p_lat - DIM_W'(1));
    last_row  = (i == m_lat - DIM_W'(1));
    next_j    = last_col ? '0 : j + DIM_W'(1);
    next_i    = last_col ? i + DIM_W'(1) : i;
    next_addr = ADDR_W'(int'(next_i) * MAX_P + int'(next_j));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m_lat    <= '0;
      p_lat    <= '0;
      i        <= '0;
      j        <= '0;
      bidx     <= '0;
      word     <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_lat <= m_clamp;
            p_lat <= p_clamp;
            i     <= '0;
            j     <= '0;
            bidx  <= '0;
            busy  <= 1'b1;
            if (m_clamp == '0 || p_clamp == '0) begin
              state <= DONE;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
              state   <= READ;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          word     <= rd_data;
          tx_data  <= rd_data[31:24];
          tx_valid <= 1'b1;
          bidx     <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (bidx == 2'd3) begin
              tx_valid <= 1'b0;
              if (last_col && last_row) begin
                state <= DONE;
              end else begin
                i       <= next_i;
                j       <= next_j;
                rd_en   <= 1'b1;
                rd_addr <= next_addr;
                state   <= READ;
              end
            end else begin
              // tx_data takes the next byte from the pre-shift word
              word    <= word << 8;
              tx_data <= word[23:16];
              bidx    <= bidx + 2'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_serializer.sv
// Bench for result_tx_serializer: RAM model, ready driver, byte/address
// scoreboard with a decoupled monitor, and directed stream scenarios.
module tb_result_tx_serializer;
  localparam int MAX_M = 4, MAX_P = 4, DIM_W = 3, ADDR_W = 4;

  logic              clk, rst, start, rd_en, tx_valid, tx_ready, busy, done;
  logic [DIM_W-1:0]  m_dim, p_dim;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [7:0]        tx_data;
  logic [2:0]        state_dbg;

  result_tx_serializer #(.MAX_M(MAX_M), .MAX_P(MAX_P), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .m_dim(m_dim), .p_dim(p_dim),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  logic [31:0]       mem [16];
  logic [7:0]        exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [7:0]        bytes_2x2 [16];
  logic [ADDR_W-1:0] addrs_2x2 [4];

  int total = 0, bad = 0, cyc = 0;
  int tx_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int start_cyc = 0, first_rd = -1, first_tx = -1, last_byte = -1;
  bit ready_mode = 0, stalled = 0;
  logic [7:0] stall_data;
  logic ram_en;
  logic [ADDR_W-1:0] ram_a;

  // clock / reset block
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Result RAM: data valid the cycle after rd_en.
  initial begin
    rd_data = '0;
    forever begin
      @(posedge clk);
      ram_en = rd_en;
      ram_a  = rd_addr;
      #1;
      if (ram_en) rd_data = mem[ram_a];
    end
  end

  // Transmitter ready: always high, or high one cycle in three.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_mode ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Monitor: pops expected bytes/addresses whenever the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(tx_valid), 32'd1);
          chk("stall_data", 32'(tx_data), 32'(stall_data));
          stalled = 0;
        end
        if (rd_en) begin
          rd_cnt++;
          if (first_rd < 0) first_rd = cyc;
          if (addr_q.size() == 0) fail_now("rd_addr_unexpected");
          else chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
        end
        if (tx_valid) begin
          if (first_tx < 0) first_tx = cyc;
          if (tx_ready) begin
            tx_cnt++;
            last_byte = cyc;
            if (exp_q.size() == 0) fail_now("tx_byte_unexpected");
            else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end else begin
            stalled    = 1;
            stall_data = tx_data;
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // driver tasks
  task automatic do_start(input int m, input int p);
    @(posedge clk); #1;
    start     = 1'b1;
    m_dim     = DIM_W'(m);
    p_dim     = DIM_W'(p);
    start_cyc = cyc;
    first_rd  = -1;
    first_tx  = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) fail_now({name, "_done_timeout"});
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic push_2x2();
    for (int k = 0; k < 4; k++) addr_q.push_back(addrs_2x2[k]);
    for (int k = 0; k < 16; k++) exp_q.push_back(bytes_2x2[k]);
  endtask

  task automatic push_stream(input int m, input int p);
    int mc = (m > MAX_M) ? MAX_M : m;
    int pc = (p > MAX_P) ? MAX_P : p;
    logic [31:0] w;
    for (int i = 0; i < mc; i++)
      for (int j = 0; j < pc; j++) begin
        addr_q.push_back(ADDR_W'(i * MAX_P + j));
        w = mem[i * MAX_P + j];
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
  endtask

  int rd0, tx0, d0, n;

  initial begin
    bytes_2x2 = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h16,
                  8'h00, 8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h32};
    addrs_2x2 = '{4'd0, 4'd1, 4'd4, 4'd5};
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0] = 32'd19; mem[1] = 32'd22; mem[4] = 32'd43; mem[5] = 32'd50;
    rst = 1'b1; start = 1'b0; m_dim = '0; p_dim = '0;

    // Reset state, with start held to show reset wins.
    repeat (2) @(posedge clk);
    #1 start = 1'b1; m_dim = 3'd2; p_dim = 3'd2;
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_busy_with_start", 32'(busy), 0);
    @(posedge clk); #1 start = 1'b0; rst = 1'b0;

    // 2x2, ready tied high: latency and 24-cycle stream.
    rd0 = rd_cnt; tx0 = tx_cnt; d0 = done_cnt;
    push_2x2();
    do_start(2, 2);
    wait_done(60, "s2x2");
    chk("s2x2_first_rd", 32'(first_rd - start_cyc), 1);
    chk("s2x2_first_tx", 32'(first_tx - start_cyc), 3);
    chk("s2x2_last_byte", 32'(last_byte - start_cyc), 24);
    chk("s2x2_bytes", 32'(tx_cnt - tx0), 16);
    chk("s2x2_reads", 32'(rd_cnt - rd0), 4);
    chk("s2x2_done", 32'(done_cnt - d0), 1);
    chk("s2x2_busy_after", 32'(busy), 0);

    // Same stream with a stalling transmitter.
    ready_mode = 1;
    rd0 = rd_cnt; tx0 = tx_cnt; d0 = done_cnt;
    push_2x2();
    do_start(2, 2);
    wait_done(200, "stall");
    chk("stall_bytes", 32'(tx_cnt - tx0), 16);
    chk("stall_done", 32'(done_cnt - d0), 1);
    chk("stall_q_empty", 32'(exp_q.size()), 0);
    ready_mode = 0;

    // Zero rows: straight to DONE.
    rd0 = rd_cnt; tx0 = tx_cnt; d0 = done_cnt;
    do_start(0, 3);
    @(negedge clk);
    chk("zero_busy_c1", 32'(busy), 1);
    chk("zero_done_c1", 32'(done), 0);
    @(negedge clk);
    chk("zero_busy_c2", 32'(busy), 0);
    chk("zero_done_c2", 32'(done), 1);
    repeat (3) @(negedge clk);
    chk("zero_reads", 32'(rd_cnt - rd0), 0);
    chk("zero_tx_valid", 32'(first_tx), 32'hFFFF_FFFF);
    chk("zero_done_cnt", 32'(done_cnt - d0), 1);

    // Reset after the 5th byte, then a fresh stream.
    d0 = done_cnt; tx0 = tx_cnt;
    push_2x2();
    do_start(2, 2);
    n = 0;
    while (tx_cnt < tx0 + 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (tx_cnt < tx0 + 5) fail_now("abort_wait_timeout");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_state", 32'(state_dbg), 0);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    tx0 = tx_cnt; d0 = done_cnt;
    push_2x2();
    do_start(2, 2);
    wait_done(60, "restart");
    chk("restart_bytes", 32'(tx_cnt - tx0), 16);
    chk("restart_done", 32'(done_cnt - d0), 1);

    // 4x4 full matrix.
    for (int k = 0; k < 16; k++) mem[k] = 32'h0102_0300 + 32'(k);
    rd0 = rd_cnt; tx0 = tx_cnt; d0 = done_cnt;
    push_stream(4, 4);
    do_start(4, 4);
    wait_done(200, "s4x4");
    chk("s4x4_bytes", 32'(tx_cnt - tx0), 64);
    chk("s4x4_reads", 32'(rd_cnt - rd0), 16);
    chk("s4x4_done", 32'(done_cnt - d0), 1);

    // Oversized M clamps to MAX_M; a second start mid-stream is ignored.
    rd0 = rd_cnt; tx0 = tx_cnt; d0 = done_cnt;
    push_stream(7, 2);
    do_start(7, 2);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; m_dim = 3'd1; p_dim = 3'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, "clamp");
    chk("clamp_bytes", 32'(tx_cnt - tx0), 32);
    chk("clamp_reads", 32'(rd_cnt - rd0), 8);
    chk("clamp_done", 32'(done_cnt - d0), 1);
    repeat (3) @(negedge clk);
    chk("clamp_no_restart", 32'(busy), 0);
    chk("final_q_empty", 32'(exp_q.size() + addr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_tx_serializer.md
RESULT_TX_SERIALIZER -- requirements
Module: result_tx_serializer

Interface
REQ-001 Parameter MAX_M, default 4, max rows of result matrix C.
REQ-002 Parameter MAX_P, default 4, max columns of result matrix C.
REQ-003 Parameter DIM_W, default 3, width of dimension inputs (holds 0..MAX).
REQ-004 Parameter ADDR_W, default 4, width of result RAM address (>= clog2(MAX_M*MAX_P)).
REQ-005 Port clk, in, 1, sole clock; all state changes on rising edge.
REQ-006 Port rst, in, 1, synchronous active-high reset.
REQ-007 Port start, in, 1, single-cycle request to stream C, sampled only in IDLE.
REQ-008 Port m_dim, in, DIM_W, row count M, sampled with start.
REQ-009 Port p_dim, in, DIM_W, column count P, sampled with start.
REQ-010 Port rd_en, out, 1, result RAM read strobe.
REQ-011 Port rd_addr, out, ADDR_W, result RAM address = i*MAX_P + j.
REQ-012 Port rd_data, in, 32, RAM word, valid exactly one cycle after rd_en.
REQ-013 Port tx_data, out, 8, byte to UART transmitter.
REQ-014 Port tx_valid, out, 1, tx_data holds a byte for the transmitter.
REQ-015 Port tx_ready, in, 1, transmitter accepts the byte this cycle.
REQ-016 Port busy, out, 1, high in every state except IDLE.
REQ-017 Port done, out, 1, one-cycle pulse at end of stream.

Function
REQ-018 FSM states SHALL be IDLE, READ, WAIT, SEND, DONE.
REQ-019 IDLE: start=1 SHALL latch m_dim/p_dim (clamped to MAX_M/MAX_P), clear i, j, byte index; next state READ, or DONE if clamped M or P is 0.
REQ-020 READ: rd_en=1 for exactly one cycle with rd_addr=i*MAX_P+j; next WAIT.
REQ-021 WAIT: rd_data SHALL be captured into a 32-bit shift word; next SEND.
REQ-022 SEND: tx_valid=1, tx_data = word[31:24]; bytes emitted MSB first, 4 per word.
REQ-023 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0; no byte dropped or duplicated.
REQ-024 A handshake (tx_valid & tx_ready) SHALL shift the word left 8 bits and increment byte index; after the 4th byte, go to READ for the next element, or DONE after the last.
REQ-025 Element order: row-major; j wraps from P-1 to 0 with i incrementing; last element is (M-1, P-1).
REQ-026 tx_valid MAY remain high across consecutive bytes of a word (back-to-back); it SHALL drop during READ/WAIT.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Total bytes per stream SHALL equal 4*M*P; total rd_en pulses SHALL equal M*P.
REQ-029 start while busy SHALL be ignored; dimensions SHALL NOT change mid-stream.
REQ-030 Latency: start at cycle 0 -> rd_en cycle 1, tx_valid first high cycle 3.
REQ-031 With tx_ready tied high, each word SHALL take 6 cycles (READ, WAIT, 4x SEND).

Reset
REQ-032 rst=1 SHALL force IDLE; tx_valid, rd_en, busy, done = 0; tx_data, rd_addr = 0; counters cleared.
REQ-033 rst asserted mid-stream SHALL abort at the next edge with no done pulse; the next start SHALL restart from element (0,0).
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
REQ-035 M=P=2, RAM {19,22,43,50}, tx_ready=1 -> bytes 00 00 00 13 00 00 00 16 00 00 00 2B 00 00 00 32, done once, 24 cycles start-to-last-byte.
REQ-036 Same stimulus, tx_ready toggling 1-of-3 cycles -> identical byte sequence, tx_data stable while stalled.
REQ-037 m_dim=0, p_dim=3 -> no rd_en, no tx_valid, done pulse cycle 2, busy cycle 1 only.
REQ-038 M=P=4, RAM word k = 0x01020300+k -> rd_addr 0..15 in order, 64 bytes, last four 01 02 03 0F.
REQ-039 rst pulsed after 5th byte of a 2x2 stream, then start -> fresh stream beginning 00 00 00 13, no done from aborted run.
REQ-040 start re-pulsed mid-stream and m_dim=7 with MAX_M=4 -> second start ignored; clamped M=4 streams 4*P words.
